// File: rtl/hs_ram_arbiter_if.sv
// hs_ram_arbiter_if: CPU RAM bus, hiscore engine port, pause handshake and the
// shared RAM port, bundled for hs_ram_arbiter. The arbiter uses the slave view;
// the surrounding system (CPU, hiscore engine, pause block, RAM) uses master.
interface hs_ram_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d;
  logic          cpu_we;
  logic [DW-1:0] cpu_q;
  logic          hs_req;
  logic [AW-1:0] hs_a;
  logic [DW-1:0] hs_d;
  logic          hs_we;
  logic [DW-1:0] hs_q;
  logic          hs_ack;
  logic          pause_req;
  logic          paused;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          busy;

  modport slave (
    input  cpu_a, cpu_d, cpu_we, hs_req, hs_a, hs_d, hs_we, paused, ram_q,
    output cpu_q, hs_q, hs_ack, pause_req, ram_a, ram_d, ram_we, busy
  );

  modport master (
    output cpu_a, cpu_d, cpu_we, hs_req, hs_a, hs_d, hs_we, paused, ram_q,
    input  cpu_q, hs_q, hs_ack, pause_req, ram_a, ram_d, ram_we, busy
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares one single-port work RAM between the game CPU and the
// hiscore save/restore engine. Pauses the CPU, waits a settle interval, hands
// the port to the hiscore engine while it requests, then hands it back to the
// CPU one cycle before releasing the pause.
// Optional feature macro HS_ARB_TIMEOUT_EN: abort a pause that never takes
// effect after 65535 cycles, pulse timeout_err, and wait for a fresh hs_req.
module hs_ram_arbiter #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned SETTLE = 4
) (
  input  logic clk_sys,
  input  logic reset,
  hs_ram_arbiter_if.slave bus
`ifdef HS_ARB_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  localparam int unsigned CW = 8;
`ifdef HS_ARB_TIMEOUT_EN
  localparam int unsigned TW = 16;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;
  logic          owner_q;
  logic          pause_req_q;
  logic          hs_ack_q;
  logic          busy_q;

  logic [AW-1:0] ram_a_c;
  logic [DW-1:0] ram_d_c;
  logic          ram_we_c;

`ifdef HS_ARB_TIMEOUT_EN
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          req_block_q, req_block_d;   // set by a timeout until hs_req drops
`endif

  // Next-state logic: pause handshake, settle countdown, grant and hand-back
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
`ifdef HS_ARB_TIMEOUT_EN
    wait_cnt_d    = '0;
    timeout_err_d = 1'b0;
    req_block_d   = req_block_q & bus.hs_req;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef HS_ARB_TIMEOUT_EN
        if (bus.hs_req && !req_block_q) state_d = ST_PAUSE;
`else
        if (bus.hs_req) state_d = ST_PAUSE;
`endif
      end
      ST_PAUSE: begin
        if (!bus.hs_req) begin
          state_d = ST_RELEASE;
        end else if (bus.paused) begin
          if (SETTLE == 0) begin
            state_d = ST_GRANT;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = CW'(SETTLE);
          end
        end
`ifdef HS_ARB_TIMEOUT_EN
        else if (wait_cnt_q == '1) begin
          state_d       = ST_RELEASE;
          timeout_err_d = 1'b1;
          req_block_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      ST_SETTLE: begin
        if (!bus.hs_req) begin
          state_d      = ST_RELEASE;
          settle_cnt_d = '0;
        end else if (!bus.paused) begin
          state_d      = ST_PAUSE;
          settle_cnt_d = '0;
        end else if (settle_cnt_q <= CW'(1)) begin
          state_d      = ST_GRANT;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q - CW'(1);
        end
      end
      ST_GRANT: begin
        if (!bus.hs_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  // State register; owner and handshake outputs are registered from the next state
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      owner_q      <= 1'b0;
      pause_req_q  <= 1'b0;
      hs_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      owner_q      <= (state_d == ST_GRANT);
      pause_req_q  <= (state_d != ST_IDLE);
      hs_ack_q     <= (state_d == ST_GRANT);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  // Pause watchdog counter, timeout pulse and re-arm block
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      req_block_q   <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      req_block_q   <= req_block_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  // RAM port mux; CPU writes only reach the RAM while the arbiter is idle
  always_comb begin
    ram_a_c  = bus.cpu_a;
    ram_d_c  = bus.cpu_d;
    ram_we_c = bus.cpu_we & ~busy_q;
    if (owner_q) begin
      ram_a_c  = bus.hs_a;
      ram_d_c  = bus.hs_d;
      ram_we_c = bus.hs_we;
    end
  end

  assign bus.ram_a     = ram_a_c;
  assign bus.ram_d     = ram_d_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.cpu_q     = bus.ram_q;
  assign bus.hs_q      = bus.ram_q;
  assign bus.pause_req = pause_req_q;
  assign bus.hs_ack    = hs_ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/hs_ram_arbiter.md
# hs_ram_arbiter

Arbitrates one single-port work RAM between the game CPU and the hiscore save/restore engine. It requests a CPU pause, waits for the pause to take effect, then waits a settle interval. It then hands the RAM port to the hiscore engine for as long as that engine holds its request, and finally returns the port to the CPU and releases the pause. It sits between the CPU core's RAM bus, the hiscore engine and the pause block, all in the `clk_sys` domain.

## Interface
Parameters:
- `AW`, 16, RAM address width
- `DW`, 8, RAM data width
- `SETTLE`, 4, cycles waited after `paused` is seen before granting (range 0–255)

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_a`  in  AW  CPU RAM address
- `cpu_d`  in  DW  CPU write data
- `cpu_we`  in  1  CPU write strobe
- `cpu_q`  out  DW  read data to CPU
- `hs_req`  in  1  hiscore access request (level)
- `hs_a`  in  AW  hiscore address
- `hs_d`  in  DW  hiscore write data
- `hs_we`  in  1  hiscore write strobe
- `hs_q`  out  DW  read data to hiscore
- `hs_ack`  out  1  hiscore owns the RAM port
- `pause_req`  out  1  pause request to the pause block
- `paused`  in  1  CPU is halted
- `ram_a`  out  AW  RAM address
- `ram_d`  out  DW  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_q`  in  DW  RAM read data (1-cycle registered read)
- `busy`  out  1  high in every state other than IDLE

## Operation
- States: IDLE, PAUSE, SETTLE, GRANT, RELEASE. The registered `owner` bit is 1 only in GRANT.
- IDLE:
  - If `hs_req`=1, go to PAUSE.
- PAUSE:
  - `pause_req`=1.
  - If `paused`=1, go to SETTLE with the counter loaded to `SETTLE`.
  - If `hs_req`=0, go to RELEASE.
- SETTLE:
  - `pause_req`=1.
  - Counter decrements each cycle; go to GRANT when it reaches 0. With `SETTLE`=0 the FSM goes directly to GRANT on the next cycle.
  - If `hs_req`=0, go to RELEASE. This takes priority over the count.
  - If `paused` drops, go back to PAUSE.
- GRANT:
  - `owner`=1, `hs_ack`=1, `pause_req`=1.
  - Stay while `hs_req`=1; when `hs_req`=0, go to RELEASE.
- RELEASE:
  - `owner`=0, `pause_req`=1 for exactly one cycle, then go to IDLE.
  - This ensures the RAM mux is back on the CPU before the CPU resumes.
- RAM mux (combinational on the registered `owner`):
  - `owner`=0: `ram_a`=`cpu_a`, `ram_d`=`cpu_d`, `ram_we`=`cpu_we` & ~`busy`.
  - `owner`=1: `ram_a`=`hs_a`, `ram_d`=`hs_d`, `ram_we`=`hs_we`.
  - CPU writes are blocked in every state other than IDLE.
  - `hs_we` is ignored when `owner`=0.
- `cpu_q` and `hs_q` both carry `ram_q` directly; each consumer qualifies it by its own ownership.
- Reset, including in the middle of GRANT: FSM to IDLE, `owner`=0, counter=0, `pause_req`/`hs_ack`/`busy`=0. Any write in progress ends that cycle.

## Timing
- Reset values of all outputs:
  - `pause_req`, `hs_ack`, `busy` = 0.
  - `ram_*` and `cpu_q`/`hs_q` follow the CPU path (`ram_we`=`cpu_we`).
- `hs_req` rising at cycle 0: `pause_req`=1 and `busy`=1 at cycle 1.
- `paused` first sampled high at cycle p: SETTLE from p+1; `hs_ack`=1 at cycle p+1+`SETTLE`.
- In GRANT, `hs_a` presented at cycle k gives valid `hs_q` at cycle k+1. An `hs_we` at cycle k writes at the cycle-k clock edge.
- `hs_req` falling at cycle r (in GRANT): `hs_ack`=0 at r+1 (RELEASE), `pause_req`=0 and `busy`=0 at r+2.
- Minimum hiscore ownership: one cycle. Back-to-back requests need at least one IDLE cycle between them.

## Configuration
- `HS_ARB_TIMEOUT_EN`:
  - Defined: a 16-bit counter runs in PAUSE. If `paused` has not been seen after 65535 cycles, the FSM goes to RELEASE and drives output `timeout_err` (1 bit, reset 0) high for one cycle. A new `hs_req` edge is required before the next attempt.
  - Not defined: no `timeout_err` port exists and PAUSE waits indefinitely.

## Test plan
- Reset, `hs_req`=0, CPU writes 0x5A to 0x6000 -> `ram_we`=1, `ram_a`=0x6000; a CPU read the next cycle returns `cpu_q`=0x5A; `busy`=0.
- `hs_req`=1 at cycle 0, `paused`=1 at cycle 3, `SETTLE`=4 -> `pause_req`=1 at cycle 1, `hs_ack`=1 at cycle 8; during cycles 1–7 a `cpu_we` produces `ram_we`=0.
- In GRANT, hiscore reads 0x6100 (preloaded 0x33) -> `hs_q`=0x33 one cycle later; it writes 0x77 to 0x6101 and a CPU read after release returns 0x77.
- `hs_req` dropped while in SETTLE -> one RELEASE cycle, `pause_req`=0 two cycles after the drop, `hs_ack` never asserted.
- `reset` asserted in GRANT -> the next cycle shows `hs_ack`=0, `pause_req`=0, `ram_a`=`cpu_a`.
- With `HS_ARB_TIMEOUT_EN` defined and `paused` held 0 -> `timeout_err` pulses once at 65536 cycles after entering PAUSE; the FSM is IDLE after the RELEASE cycle and `hs_req` held at 1 does not retrigger.
